reset_sequencer: RTL and testbench

Parametrised multi-stage reset sequencer, the successor to the single-counter reset delay in the top level. It synchronises an external reset request and a PLL-lock indication into the system clock domain. It then releases N reset domains in a fixed, staggered order: for example SDRAM controller, then display pipeline, then SPI slave. Any request, lock loss or re-sequence command re-asserts every domain and restarts the sequence. It sits in the top level between the board and GPIO reset sources and every block that takes a reset.

---
 rtl/reset_sequencer_if.sv | 31 +++
 rtl/reset_sequencer.sv | 133 +++++++++++++
 tb/tb_reset_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Reset sequencer bus: asynchronous reset sources in, per-domain resets out.
interface reset_sequencer_if #(
    parameter int unsigned N_STAGES = 3
);
    logic                iREQ;
    logic                iLOCK;
    logic                iRESEQ;
    logic [N_STAGES-1:0] oRST;
    logic [N_STAGES-1:0] oPULSE;
    logic                oDONE;

    // Reset source side (board, GPIO, PLL).
    modport master (
        output iREQ,
        output iLOCK,
        output iRESEQ,
        input  oRST,
        input  oPULSE,
        input  oDONE
    );

    // Sequencer side.
    modport slave (
        input  iREQ,
        input  iLOCK,
        input  iRESEQ,
        output oRST,
        output oPULSE,
        output oDONE
    );
endinterface

// File: rtl/reset_sequencer.sv
// Multi-stage reset sequencer: synchronises reset request and PLL lock,
// then releases N_STAGES reset domains in staggered order. Any request,
// lock loss or re-sequence strobe re-asserts every domain at once.
module reset_sequencer #(
    parameter int unsigned N_STAGES    = 3,
    parameter int unsigned BASE_DLY    = 4,
    parameter int unsigned STEP_DLY    = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              iCLK,
    input  logic              iRST,
    reset_sequencer_if.slave  bus
);

    localparam int unsigned T_MAX = BASE_DLY + (N_STAGES - 1) * STEP_DLY;
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);

    localparam logic [1:0] S_HOLD  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [SYNC_STAGES-1:0] req_sync;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   req_s;
    logic                   lock_s;
    logic                   abort;

    logic [1:0]          state,   state_nx;
    logic [CNT_W-1:0]    cnt,     cnt_nx;
    logic [CNT_W-1:0]    cnt_inc;
    logic [N_STAGES-1:0] rst_q,   rst_nx;
    logic [N_STAGES-1:0] pulse_q, pulse_nx;
    logic                done_q,  done_nx;

    // Synchronisers; request chain powers up asserted, lock chain unlocked.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            req_sync  <= '1;
            lock_sync <= '0;
        end else begin
            req_sync  <= {req_sync[SYNC_STAGES-2:0], bus.iREQ};
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.iLOCK};
        end
    end

    assign req_s   = req_sync[SYNC_STAGES-1];
    assign lock_s  = lock_sync[SYNC_STAGES-1];
    // iRESEQ is already in the iCLK domain, so it aborts on the edge it is seen.
    assign abort   = req_s | ~lock_s | bus.iRESEQ;
    assign cnt_inc = cnt + CNT_W'(1);

    // State, counter and output registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= S_HOLD;
            cnt     <= '0;
            rst_q   <= '1;
            pulse_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            rst_q   <= rst_nx;
            pulse_q <= pulse_nx;
            done_q  <= done_nx;
        end
    end

    // Next-state, counter and release decode; abort always wins over release.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rst_nx   = rst_q;
        pulse_nx = '0;
        done_nx  = done_q;

        case (state)
            S_HOLD: begin
                cnt_nx  = '0;
                rst_nx  = '1;
                done_nx = 1'b0;
                if (!abort) begin
                    state_nx = S_COUNT;
                end
            end

            S_COUNT: begin
                if (abort) begin
                    state_nx = S_HOLD;
                    cnt_nx   = '0;
                    rst_nx   = '1;
                    done_nx  = 1'b0;
                end else begin
                    cnt_nx = cnt_inc;
                    for (int unsigned k = 0; k < N_STAGES; k++) begin
                        if (cnt_inc >= CNT_W'(BASE_DLY + k * STEP_DLY)) begin
                            rst_nx[k] = 1'b0;
                        end
                    end
                    pulse_nx = rst_q & ~rst_nx;
                    if (cnt_inc == CNT_W'(T_MAX)) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                    end
                end
            end

            S_DONE: begin
                if (abort) begin
                    state_nx = S_HOLD;
                    cnt_nx   = '0;
                    rst_nx   = '1;
                    done_nx  = 1'b0;
                end else begin
                    rst_nx  = '0;
                    done_nx = 1'b1;
                end
            end

            default: begin
                state_nx = S_HOLD;
                cnt_nx   = '0;
                rst_nx   = '1;
                done_nx  = 1'b0;
            end
        endcase
    end

    assign bus.oRST   = rst_q;
    assign bus.oPULSE = pulse_q;
    assign bus.oDONE  = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scenario bench for reset_sequencer (N_STAGES=3, BASE_DLY=4, STEP_DLY=3, SYNC_STAGES=2).
module tb_reset_sequencer;

    logic iCLK;
    logic iRST;

    reset_sequencer_if #(.N_STAGES(3)) bus ();

    reset_sequencer #(
        .N_STAGES    (3),
        .BASE_DLY    (4),
        .STEP_DLY    (3),
        .SYNC_STAGES (2)
    ) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    int tests_run = 0;
    int failed    = 0;

    // Expected {oDONE, oPULSE[2:0], oRST[2:0]} per edge.
    logic [6:0] sb_q[$];
    logic [6:0] exp_v;
    logic [6:0] obs;

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Expected outputs at edge n when COUNT was entered at edge s (s<=0: never).
    function automatic logic [6:0] exp_vec(int n, int s);
        logic [2:0] r;
        logic [2:0] p;
        logic       d;
        for (int k = 0; k < 3; k++) begin
            r[k] = !(s > 0 && n >= s + 4 + 3 * k);
            p[k] = (s > 0 && n == s + 4 + 3 * k);
        end
        d = (s > 0 && n >= s + 10);
        return {d, p, r};
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Holds iRST for two edges; the next edge after this returns is edge 1.
    task automatic do_reset();
        iRST       = 1'b1;
        bus.iREQ   = 1'b0;
        bus.iLOCK  = 1'b1;
        bus.iRESEQ = 1'b0;
        tick();
        tick();
        iRST = 1'b0;
    endtask

    task automatic test_reset();
        iRST       = 1'b1;
        bus.iREQ   = 1'b1;
        bus.iLOCK  = 1'b0;
        bus.iRESEQ = 1'b0;
        sb_q.push_back(7'b000_0111);
        tick();
        tick();
        exp_v = sb_q.pop_front();
        obs   = {bus.oDONE, bus.oPULSE, bus.oRST};
        tests_run++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL reset_state: got %b expected %b", obs, exp_v);
        end
    endtask

    task automatic test_power_up();
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            sb_q.push_back(exp_vec(n, 3));
            tick();
            exp_v = sb_q.pop_front();
            obs   = {bus.oDONE, bus.oPULSE, bus.oRST};
            tests_run++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL power_up edge %0d: got %b expected %b", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_mid_request();
        do_reset();
        for (int n = 1; n <= 22; n++) begin
            bus.iREQ = (n >= 9 && n <= 11);
            sb_q.push_back((n < 11) ? exp_vec(n, 3) : exp_vec(n, 14));
            tick();
            exp_v = sb_q.pop_front();
            obs   = {bus.oDONE, bus.oPULSE, bus.oRST};
            tests_run++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL mid_request edge %0d: got %b expected %b", n, obs, exp_v);
            end
        end
        bus.iREQ = 1'b0;
    endtask

    task automatic test_lock_loss();
        do_reset();
        for (int n = 1; n <= 34; n++) begin
            bus.iLOCK = !(n >= 20 && n <= 26);
            sb_q.push_back((n < 22) ? exp_vec(n, 3) : exp_vec(n, 29));
            tick();
            exp_v = sb_q.pop_front();
            obs   = {bus.oDONE, bus.oPULSE, bus.oRST};
            tests_run++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL lock_loss edge %0d: got %b expected %b", n, obs, exp_v);
            end
        end
        bus.iLOCK = 1'b1;
    endtask

    task automatic test_reseq();
        do_reset();
        for (int n = 1; n <= 32; n++) begin
            bus.iRESEQ = (n == 20);
            sb_q.push_back((n < 20) ? exp_vec(n, 3) : exp_vec(n, 21));
            tick();
            exp_v = sb_q.pop_front();
            obs   = {bus.oDONE, bus.oPULSE, bus.oRST};
            tests_run++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL reseq edge %0d: got %b expected %b", n, obs, exp_v);
            end
        end
        bus.iRESEQ = 1'b0;
    endtask

    task automatic test_collision();
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            bus.iRESEQ = (n == 7);
            sb_q.push_back((n < 7) ? exp_vec(n, 3) : exp_vec(n, 8));
            tick();
            exp_v = sb_q.pop_front();
            obs   = {bus.oDONE, bus.oPULSE, bus.oRST};
            tests_run++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL collision edge %0d: got %b expected %b", n, obs, exp_v);
            end
        end
        bus.iRESEQ = 1'b0;
    endtask

    task automatic test_sync_reset();
        do_reset();
        for (int n = 1; n <= 7; n++) begin
            sb_q.push_back(exp_vec(n, 3));
            tick();
            exp_v = sb_q.pop_front();
            obs   = {bus.oDONE, bus.oPULSE, bus.oRST};
            tests_run++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL sync_reset_pre edge %0d: got %b expected %b", n, obs, exp_v);
            end
        end
        iRST = 1'b1;
        sb_q.push_back(7'b000_0111);
        tick();
        exp_v = sb_q.pop_front();
        obs   = {bus.oDONE, bus.oPULSE, bus.oRST};
        tests_run++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL sync_reset_edge8: got %b expected %b", obs, exp_v);
        end
        iRST = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            sb_q.push_back(exp_vec(n, 3));
            tick();
            exp_v = sb_q.pop_front();
            obs   = {bus.oDONE, bus.oPULSE, bus.oRST};
            tests_run++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL sync_reset_post edge %0d: got %b expected %b", n, obs, exp_v);
            end
        end
    endtask

    initial begin
        iRST       = 1'b1;
        bus.iREQ   = 1'b0;
        bus.iLOCK  = 1'b1;
        bus.iRESEQ = 1'b0;
        test_reset();
        test_power_up();
        test_mid_request();
        test_lock_loss();
        test_reseq();
        test_collision();
        test_sync_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
